// File: rtl/wired_bus_arbiter_if.sv
// Requester and memory-bus signal bundle for wired_bus_arbiter.
// The arbiter masters the bus, so it takes the master modport; the environment takes slave.
interface wired_bus_arbiter_if #(
  parameter int N_REQ  = 3,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int LEN_W  = 4
);
  logic [N_REQ-1:0]        req_valid_i;
  logic [N_REQ-1:0]        req_ready_o;
  logic [N_REQ*ADDR_W-1:0] req_addr_i;
  logic [N_REQ*LEN_W-1:0]  req_len_i;
  logic [N_REQ-1:0]        req_we_i;
  logic [N_REQ*DATA_W-1:0] req_wdata_i;
  logic [N_REQ-1:0]        kill_i;
  logic [N_REQ-1:0]        resp_valid_o;
  logic [N_REQ-1:0]        resp_ready_i;
  logic [DATA_W-1:0]       resp_data_o;
  logic                    resp_last_o;
  logic                    bus_req_valid_o;
  logic                    bus_req_ready_i;
  logic [ADDR_W-1:0]       bus_req_addr_o;
  logic [LEN_W-1:0]        bus_req_len_o;
  logic                    bus_req_we_o;
  logic [DATA_W-1:0]       bus_req_wdata_o;
  logic                    bus_resp_valid_i;
  logic                    bus_resp_ready_o;
  logic [DATA_W-1:0]       bus_resp_data_i;
  logic                    busy_o;

  modport master (
    input  req_valid_i, req_addr_i, req_len_i, req_we_i, req_wdata_i, kill_i, resp_ready_i,
    input  bus_req_ready_i, bus_resp_valid_i, bus_resp_data_i,
    output req_ready_o, resp_valid_o, resp_data_o, resp_last_o,
    output bus_req_valid_o, bus_req_addr_o, bus_req_len_o, bus_req_we_o, bus_req_wdata_o,
    output bus_resp_ready_o, busy_o
  );

  modport slave (
    output req_valid_i, req_addr_i, req_len_i, req_we_i, req_wdata_i, kill_i, resp_ready_i,
    output bus_req_ready_i, bus_resp_valid_i, bus_resp_data_i,
    input  req_ready_o, resp_valid_o, resp_data_o, resp_last_o,
    input  bus_req_valid_o, bus_req_addr_o, bus_req_len_o, bus_req_we_o, bus_req_wdata_o,
    input  bus_resp_ready_o, busy_o
  );
endinterface

// File: rtl/wired_bus_arbiter.sv
// Round-robin arbiter sharing one memory bus port between icache, dcache and uncached requesters.
// A grant is locked from acceptance until the final response beat has drained from the bus.
module wired_bus_arbiter #(
  parameter int N_REQ  = 3,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int LEN_W  = 4
) (
  input logic                 clk,
  input logic                 rst,
  wired_bus_arbiter_if.master bus
);
  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_e;

  state_e             state_r;
  state_e             state_s;
  logic [PTR_W-1:0]   rr_ptr_r;
  logic [PTR_W-1:0]   grant_r;
  logic [LEN_W-1:0]   beat_cnt_r;
  logic               killed_r;
  logic [ADDR_W-1:0]  addr_r;
  logic [LEN_W-1:0]   len_r;
  logic               we_r;
  logic [DATA_W-1:0]  wdata_r;

  logic               sel_found_s;
  logic [PTR_W-1:0]   sel_idx_s;
  logic               killed_eff_s;
  logic               last_s;
  logic               beat_hs_s;

  function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base, input int off);
    logic [PTR_W:0] sum_v;
    sum_v = {1'b0, base} + (PTR_W+1)'(off);
    sum_v = (sum_v >= (PTR_W+1)'(N_REQ)) ? sum_v - (PTR_W+1)'(N_REQ) : sum_v;
    return sum_v[PTR_W-1:0];
  endfunction

  function automatic logic [N_REQ-1:0] one_hot(input logic [PTR_W-1:0] idx);
    logic [N_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Round-robin pick: scan from the far end so the offset closest to rr_ptr wins.
  always_comb begin
    sel_found_s = 1'b0;
    sel_idx_s   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (bus.req_valid_i[wrap_idx(rr_ptr_r, k)]) begin
        sel_found_s = 1'b1;
        sel_idx_s   = wrap_idx(rr_ptr_r, k);
      end else begin
        sel_found_s = sel_found_s;
      end
    end
  end

  // len_r is forced to zero for writes, so one compare covers both beat counts.
  assign killed_eff_s = killed_r | bus.kill_i[grant_r];
  assign last_s       = (beat_cnt_r == len_r);
  assign beat_hs_s    = bus.bus_resp_valid_i & bus.bus_resp_ready_o;

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    state_s = sel_found_s ? ADDR : IDLE;
      ADDR:    state_s = bus.bus_req_ready_i ? DATA : ADDR;
      DATA:    state_s = (beat_hs_s && last_s) ? IDLE : DATA;
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Request capture, beat counting, kill tracking and round-robin pointer update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_r   <= '0;
      grant_r    <= '0;
      beat_cnt_r <= '0;
      killed_r   <= 1'b0;
      addr_r     <= '0;
      len_r      <= '0;
      we_r       <= 1'b0;
      wdata_r    <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (sel_found_s) begin
            grant_r  <= sel_idx_s;
            addr_r   <= bus.req_addr_i[sel_idx_s*ADDR_W +: ADDR_W];
            len_r    <= bus.req_we_i[sel_idx_s] ? '0 : bus.req_len_i[sel_idx_s*LEN_W +: LEN_W];
            we_r     <= bus.req_we_i[sel_idx_s];
            wdata_r  <= bus.req_wdata_i[sel_idx_s*DATA_W +: DATA_W];
            killed_r <= 1'b0;
          end else begin
            killed_r <= 1'b0;
          end
        end
        ADDR: begin
          killed_r <= killed_eff_s;
          if (bus.bus_req_ready_i) begin
            beat_cnt_r <= '0;
          end else begin
            beat_cnt_r <= beat_cnt_r;
          end
        end
        DATA: begin
          if (beat_hs_s && last_s) begin
            beat_cnt_r <= beat_cnt_r + LEN_W'(1);
            rr_ptr_r   <= wrap_idx(grant_r, 1);
            killed_r   <= 1'b0;
          end else if (beat_hs_s) begin
            beat_cnt_r <= beat_cnt_r + LEN_W'(1);
            killed_r   <= killed_eff_s;
          end else begin
            killed_r   <= killed_eff_s;
          end
        end
        default: begin
          killed_r <= 1'b0;
        end
      endcase
    end
  end

  // Requester-side outputs; req_ready is masked by rst so it reads zero while reset is held.
  always_comb begin
    bus.req_ready_o  = '0;
    bus.resp_valid_o = '0;
    if (state_r == IDLE && sel_found_s && !rst) begin
      bus.req_ready_o = one_hot(sel_idx_s);
    end else begin
      bus.req_ready_o = '0;
    end
    if (state_r == DATA && bus.bus_resp_valid_i && !killed_eff_s) begin
      bus.resp_valid_o = one_hot(grant_r);
    end else begin
      bus.resp_valid_o = '0;
    end
  end

  assign bus.resp_data_o      = (state_r == DATA) ? bus.bus_resp_data_i : '0;
  assign bus.resp_last_o      = (state_r == DATA) && last_s;
  assign bus.bus_resp_ready_o = (state_r == DATA) && (killed_eff_s || bus.resp_ready_i[grant_r]);
  assign bus.bus_req_valid_o  = (state_r == ADDR);
  assign bus.bus_req_addr_o   = addr_r;
  assign bus.bus_req_len_o    = len_r;
  assign bus.bus_req_we_o     = we_r;
  assign bus.bus_req_wdata_o  = wdata_r;
  assign bus.busy_o           = (state_r != IDLE);
endmodule
